// File: rtl/tape_pkg.sv
// Shared types and constants for the CSW cassette playback block.
// Holds the sequencer state encoding and the CSW framing constants.
package tape_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXT0  = 3'd2,
        ST_EXT1  = 3'd3,
        ST_EXT2  = 3'd4,
        ST_EXT3  = 3'd5,
        ST_RUN   = 3'd6
    } state_t;

    // A zero byte announces a 32-bit little-endian length in the next four bytes.
    localparam logic [7:0] CSW_EXT_MARKER = 8'h00;

    localparam int SAMPLE_DIV_DEFAULT = 363;

endpackage

// File: rtl/tape_fifo.sv
// Synchronous byte FIFO with show-ahead read data and a flush input.
// Simultaneous push and pop are both honoured, also when full or empty.
module tape_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push & (!full | pop);
    assign pop_ok  = pop & (!empty | push);
    // When empty, a same-cycle push is passed straight through to the reader.
    assign rdata   = empty ? wdata : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/tape_csw_player.sv
// CSW v1 cassette player: buffers RLE pulse lengths and toggles tape_level
// after each length has elapsed in sample periods derived from ce_16.
module tape_csw_player
    import tape_pkg::*;
#(
    parameter int   FIFO_DEPTH = 16,
    parameter int   SAMPLE_DIV = SAMPLE_DIV_DEFAULT,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_16,
    input  logic       play,
    input  logic       stop,
    input  logic       motor,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       tape_level,
    output logic       playing,
    output logic       underrun,
    output logic [2:0] dbg_state
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t             state_q, state_d;
    logic [31:0]        len_q, len_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               level_q, level_d;
    logic               underrun_q, underrun_d;
    logic               rdy_en_q;

    logic [7:0]         fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_push;
    logic               fifo_pop;
    logic               adv;
    logic               tick;

    // Handshake: a byte transfers on a clk edge where din_valid & din_ready;
    // din_valid may be raised at any time, din_ready is low while full or in reset.
    assign din_ready  = rdy_en_q & !fifo_full;
    assign fifo_push  = din_valid & din_ready & !stop;
    assign adv        = play & motor;
    assign tick       = adv & ce_16 & (div_q == DIV_LAST);
    assign tape_level = level_q;
    assign underrun   = underrun_q;
    assign playing    = (state_q == ST_RUN) & adv;
    assign dbg_state  = state_q;

    tape_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .clear (stop),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (din),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        level_d    = level_q;
        underrun_d = underrun_q;
        fifo_pop   = 1'b0;
        div_d      = div_q;

        // The divider free-runs across pulses so record boundaries cost no time.
        if (adv && ce_16) div_d = tick ? '0 : div_q + DIV_W'(1);

        case (state_q)
            ST_IDLE: if (play) state_d = ST_FETCH;
            ST_FETCH: if (play && !fifo_empty) begin
                fifo_pop = 1'b1;
                if (fifo_rdata == CSW_EXT_MARKER) begin
                    state_d = ST_EXT0;
                end else begin
                    len_d   = {24'h0, fifo_rdata};
                    state_d = ST_RUN;
                end
            end
            ST_EXT0: if (play && !fifo_empty) begin
                fifo_pop   = 1'b1;
                len_d[7:0] = fifo_rdata;
                state_d    = ST_EXT1;
            end
            ST_EXT1: if (play && !fifo_empty) begin
                fifo_pop    = 1'b1;
                len_d[15:8] = fifo_rdata;
                state_d     = ST_EXT2;
            end
            ST_EXT2: if (play && !fifo_empty) begin
                fifo_pop     = 1'b1;
                len_d[23:16] = fifo_rdata;
                state_d      = ST_EXT3;
            end
            ST_EXT3: if (play && !fifo_empty) begin
                fifo_pop     = 1'b1;
                len_d[31:24] = fifo_rdata;
                state_d      = ({fifo_rdata, len_q[23:0]} == 32'h0) ? ST_FETCH : ST_RUN;
            end
            ST_RUN: if (tick) begin
                len_d = len_q - 32'd1;
                if (len_q == 32'd1) begin
                    level_d = !level_q;
                    state_d = ST_FETCH;
                    if (fifo_count == '0) underrun_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (stop) begin
            state_d    = ST_IDLE;
            len_d      = '0;
            level_d    = INIT_LEVEL;
            underrun_d = 1'b0;
            div_d      = '0;
            fifo_pop   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            div_q      <= '0;
            level_q    <= INIT_LEVEL;
            underrun_q <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            div_q      <= div_d;
            level_q    <= level_d;
            underrun_q <= underrun_d;
            rdy_en_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tape_csw_player.sv
// Directed bench for tape_csw_player: pulse timing, extended lengths, motor
// freeze, FIFO fill/flush, underrun and asynchronous reset.
module tb_tape_csw_player;

    localparam int DEPTH = 16;
    localparam int DIV   = 4;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd6;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce_16;
    logic       play;
    logic       stop;
    logic       motor;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       tape_level;
    logic       playing;
    logic       underrun;
    logic [2:0] dbg_state;

    int          total = 0;
    int          bad   = 0;
    int          ce_cnt;
    logic        last_level;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    tape_csw_player #(
        .FIFO_DEPTH (DEPTH),
        .SAMPLE_DIV (DIV),
        .INIT_LEVEL (1'b0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce_16      (ce_16),
        .play       (play),
        .stop       (stop),
        .motor      (motor),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .tape_level (tape_level),
        .playing    (playing),
        .underrun   (underrun),
        .dbg_state  (dbg_state)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        int waited = 0;
        while (din_ready !== 1'b1 && waited < 64) begin
            tick();
            waited++;
        end
        if (din_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL push_timeout: din_ready=%b want 1", din_ready);
        end else begin
            din       = b;
            din_valid = 1'b1;
            tick();
            din_valid = 1'b0;
        end
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic start_capture();
        ce_cnt     = 0;
        last_level = tape_level;
        got_q.delete();
        exp_q.delete();
    endtask

    // Each ce_16 pulse is one clk high then one clk low; toggles are logged by pulse index.
    task automatic run_ce(input int n);
        for (int i = 0; i < n; i++) begin
            ce_16 = 1'b1;
            tick();
            ce_16 = 1'b0;
            ce_cnt++;
            if (tape_level !== last_level) begin
                got_q.push_back(ce_cnt[15:0]);
                last_level = tape_level;
            end
            tick();
        end
    endtask

    // tests
    task automatic test_reset();
        reset_n = 1'b0;
        ticks(3);
        total++; if (tape_level !== 1'b0) begin bad++; $display("FAIL rst_level: got %b want 0", tape_level); end
        total++; if (playing !== 1'b0) begin bad++; $display("FAIL rst_playing: got %b want 0", playing); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun: got %b want 0", underrun); end
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", din_ready); end
        total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", dbg_state, S_IDLE); end
        #3 reset_n = 1'b1;
        #1;
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_release: got %b want 0", din_ready); end
        tick();
        total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_first_clk: got %b want 1", din_ready); end
    endtask

    task automatic test_basic();
        play  = 1'b1;
        motor = 1'b1;
        tick();
        push_byte(8'h02);
        push_byte(8'h03);
        ticks(2);
        total++; if (dbg_state !== S_RUN) begin bad++; $display("FAIL basic_state_run: got %0d want %0d", dbg_state, S_RUN); end
        start_capture();
        exp_q.push_back(16'd8);
        exp_q.push_back(16'd20);
        run_ce(10);
        total++; if (playing !== 1'b1) begin bad++; $display("FAIL basic_playing: got %b want 1", playing); end
        run_ce(14);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL basic_toggle_cnt: got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_toggle_at[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
            end
        end
        total++; if (tape_level !== 1'b0) begin bad++; $display("FAIL basic_level: got %b want 0", tape_level); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL basic_underrun: got %b want 1", underrun); end
    endtask

    task automatic test_ext_length();
        pulse_stop();
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ext_stop_underrun: got %b want 0", underrun); end
        push_byte(8'h00);
        push_byte(8'h05);
        push_byte(8'h00);
        push_byte(8'h00);
        push_byte(8'h00);
        ticks(2);
        total++; if (dbg_state !== S_RUN) begin bad++; $display("FAIL ext_state_run: got %0d want %0d", dbg_state, S_RUN); end
        start_capture();
        exp_q.push_back(16'd20);
        run_ce(24);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL ext_toggle_cnt: got %0d want %0d", got_q.size(), exp_q.size());
        end else if (got_q[0] !== exp_q[0]) begin
            bad++; $display("FAIL ext_toggle_at: got %0d want %0d", got_q[0], exp_q[0]);
        end
        for (int i = 0; i < 5; i++) push_byte(8'h00);
        ticks(3);
        total++; if (tape_level !== 1'b1) begin bad++; $display("FAIL ext_zero_level: got %b want 1", tape_level); end
        total++; if (dbg_state !== S_FETCH) begin bad++; $display("FAIL ext_zero_state: got %0d want %0d", dbg_state, S_FETCH); end
        total++; if (dut.fifo_count !== 5'd0) begin bad++; $display("FAIL ext_zero_count: got %0d want 0", dut.fifo_count); end
    endtask

    task automatic test_motor_freeze();
        pulse_stop();
        push_byte(8'h03);
        ticks(2);
        start_capture();
        exp_q.push_back(16'd12);
        run_ce(5);
        motor = 1'b0;
        for (int i = 0; i < 25; i++) begin
            ce_16 = 1'b1;
            tick();
            ce_16 = 1'b0;
            tick();
        end
        total++; if (tape_level !== 1'b0) begin bad++; $display("FAIL motor_frozen_level: got %b want 0", tape_level); end
        total++; if (playing !== 1'b0) begin bad++; $display("FAIL motor_frozen_playing: got %b want 0", playing); end
        total++; if (dbg_state !== S_RUN) begin bad++; $display("FAIL motor_frozen_state: got %0d want %0d", dbg_state, S_RUN); end
        motor = 1'b1;
        run_ce(10);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL motor_toggle_cnt: got %0d want %0d", got_q.size(), exp_q.size());
        end else if (got_q[0] !== exp_q[0]) begin
            bad++; $display("FAIL motor_toggle_at: got %0d want %0d", got_q[0], exp_q[0]);
        end
        motor = 1'b0;
        push_byte(8'h02);
        ticks(2);
        total++; if (dbg_state !== S_RUN) begin bad++; $display("FAIL motor_off_preload: got %0d want %0d", dbg_state, S_RUN); end
        total++; if (playing !== 1'b0) begin bad++; $display("FAIL motor_off_playing: got %b want 0", playing); end
        motor = 1'b1;
        #1;
        total++; if (playing !== 1'b1) begin bad++; $display("FAIL motor_on_playing: got %b want 1", playing); end
    endtask

    task automatic test_fifo_fill();
        int accepted   = 0;
        int first_full = -1;
        play = 1'b0;
        pulse_stop();
        din_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = 8'(i + 1);
            if (din_ready === 1'b1) accepted++;
            else if (first_full < 0) first_full = i;
            tick();
        end
        din_valid = 1'b0;
        total++; if (accepted != DEPTH) begin bad++; $display("FAIL fill_accepted: got %0d want %0d", accepted, DEPTH); end
        total++; if (first_full != DEPTH) begin bad++; $display("FAIL fill_ready_drop: got %0d want %0d", first_full, DEPTH); end
        total++; if (dut.fifo_count !== 5'd16) begin bad++; $display("FAIL fill_count: got %0d want 16", dut.fifo_count); end
        stop      = 1'b1;
        din_valid = 1'b1;
        tick();
        total++; if (dut.fifo_count !== 5'd0) begin bad++; $display("FAIL fill_flush: got %0d want 0", dut.fifo_count); end
        tick();
        stop      = 1'b0;
        din_valid = 1'b0;
        total++; if (dut.fifo_count !== 5'd0) begin bad++; $display("FAIL stop_beats_push: got %0d want 0", dut.fifo_count); end
        total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL flush_ready: got %b want 1", din_ready); end
    endtask

    task automatic test_underrun();
        play  = 1'b1;
        motor = 1'b1;
        pulse_stop();
        push_byte(8'h01);
        ticks(2);
        start_capture();
        exp_q.push_back(16'd4);
        run_ce(6);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL under_toggle_cnt: got %0d want %0d", got_q.size(), exp_q.size());
        end else if (got_q[0] !== exp_q[0]) begin
            bad++; $display("FAIL under_toggle_at: got %0d want %0d", got_q[0], exp_q[0]);
        end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL under_flag: got %b want 1", underrun); end
        total++; if (tape_level !== 1'b1) begin bad++; $display("FAIL under_level_held: got %b want 1", tape_level); end
        total++; if (dbg_state !== S_FETCH) begin bad++; $display("FAIL under_state: got %0d want %0d", dbg_state, S_FETCH); end
        pulse_stop();
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL under_stop_clear: got %b want 0", underrun); end
        total++; if (tape_level !== 1'b0) begin bad++; $display("FAIL under_stop_level: got %b want 0", tape_level); end
    endtask

    task automatic test_async_reset();
        pulse_stop();
        push_byte(8'h01);
        push_byte(8'h04);
        push_byte(8'h07);
        ticks(2);
        start_capture();
        run_ce(6);
        total++; if (tape_level !== 1'b1) begin bad++; $display("FAIL arst_pre_level: got %b want 1", tape_level); end
        total++; if (playing !== 1'b1) begin bad++; $display("FAIL arst_pre_playing: got %b want 1", playing); end
        #3 reset_n = 1'b0;
        #1;
        total++; if (tape_level !== 1'b0) begin bad++; $display("FAIL arst_level: got %b want 0", tape_level); end
        total++; if (playing !== 1'b0) begin bad++; $display("FAIL arst_playing: got %b want 0", playing); end
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL arst_ready: got %b want 0", din_ready); end
        total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL arst_state: got %0d want %0d", dbg_state, S_IDLE); end
        tick();
        reset_n = 1'b1;
        tick();
        total++; if (dut.fifo_count !== 5'd0) begin bad++; $display("FAIL arst_fifo_empty: got %0d want 0", dut.fifo_count); end
        total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL arst_ready_after: got %b want 1", din_ready); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL arst_underrun: got %b want 0", underrun); end
    endtask

    initial begin
        ce_16     = 1'b0;
        play      = 1'b0;
        stop      = 1'b0;
        motor     = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        reset_n   = 1'b0;
        test_reset();
        test_basic();
        test_ext_length();
        test_motor_freeze();
        test_fifo_fill();
        test_underrun();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
